// File: rtl/fifo_wr_port_arbiter.sv
// Write-domain controller of the async FIFO: round-robin/burst-locked sharing of the
// write port, binary/Gray write pointer and full flag. Optional almost-full: FIFO_WR_AFULL_EN.
module fifo_wr_port_arbiter #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned DATASIZE     = 32,
  parameter int unsigned NREQ         = 4,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic                        wclk_i,
  input  logic                        wrst_n_i,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ-1:0]             req_last_i,
  input  logic [NREQ*DATASIZE-1:0]    req_data_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [ADDRSIZE:0]           rptr_sync_g_i,
  output logic                        winc_o,
  output logic [ADDRSIZE-1:0]         waddr_o,
  output logic [DATASIZE-1:0]         wdata_o,
  output logic [ADDRSIZE:0]           wptr_g_o,
  output logic                        wfull_o,
  output logic [$clog2(NREQ)-1:0]     grant_id_o,
  output logic                        awfull_o
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [PW-1:0]   wbin_q, wbin_d;
  logic [PW-1:0]   wgray_q, wgray_d;
  logic            wfull_q, wfull_d;

  logic [GW-1:0]   cand_c;
  logic            cand_vld_c;
  logic [GW-1:0]   sel_c;
  logic            sel_vld_c;
  logic            accept_c;
  logic [PW-1:0]   rptr_full_c;

  logic [DATASIZE-1:0] data_arr [NREQ];

  // Unpack requester data lanes
  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    assign data_arr[k] = req_data_i[k*DATASIZE +: DATASIZE];
  end

  // Round-robin candidate: first valid requester after the last owner
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] j;
    idx        = 0;
    j          = '0;
    cand_c     = grant_q;
    cand_vld_c = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = 32'(grant_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      j = GW'(idx);
      if (!cand_vld_c && req_valid_i[j]) begin
        cand_vld_c = 1'b1;
        cand_c     = j;
      end
    end
  end

  // Full compare target: read pointer with its two MSBs inverted
  assign rptr_full_c = {~rptr_sync_g_i[ADDRSIZE:ADDRSIZE-1], rptr_sync_g_i[ADDRSIZE-2:0]};

  // Grant selection, lock tracking and next pointer state
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_c       = grant_q;
    sel_vld_c   = 1'b0;
    req_ready_o = '0;
    case (state_q)
      ARB: begin
        sel_c     = cand_c;
        sel_vld_c = cand_vld_c;
      end
      HOLD: begin
        sel_c     = grant_q;
        sel_vld_c = req_valid_i[grant_q];
      end
      default: begin
        sel_c     = grant_q;
        sel_vld_c = 1'b0;
      end
    endcase
    // Reset gates the accept so no beat is taken while held in reset
    accept_c = sel_vld_c && !wfull_q && wrst_n_i;
    if (accept_c) begin
      req_ready_o[sel_c] = 1'b1;
      grant_d            = sel_c;
      state_d            = req_last_i[sel_c] ? ARB : HOLD;
    end
    wbin_d  = wbin_q + PW'(accept_c);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    wfull_d = (wgray_d == rptr_full_c);
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      state_q <= ARB;
      grant_q <= GW'(NREQ - 1);
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

  assign winc_o     = |req_ready_o;
  assign waddr_o    = wbin_q[ADDRSIZE-1:0];
  assign wdata_o    = data_arr[sel_c];
  assign wptr_g_o   = wgray_q;
  assign wfull_o    = wfull_q;
  assign grant_id_o = grant_q;

`ifdef FIFO_WR_AFULL_EN
  localparam int unsigned DEPTH = 32'(1) << ADDRSIZE;

  logic [PW-1:0] rbin_c;
  logic [PW-1:0] wlvl_c;
  logic          awfull_q, awfull_d;

  // Occupancy against the synchronised read pointer, converted back to binary
  always_comb begin
    rbin_c = rptr_sync_g_i;
    for (int unsigned i = 1; i < PW; i++) begin
      rbin_c = rbin_c ^ (rptr_sync_g_i >> i);
    end
    wlvl_c   = wbin_d - rbin_c;
    awfull_d = (32'(wlvl_c) >= (DEPTH - AFULL_THRESH));
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      awfull_q <= 1'b0;
    end else begin
      awfull_q <= awfull_d;
    end
  end

  assign awfull_o = awfull_q;
`else
  logic unused_afull_thresh;

  assign unused_afull_thresh = ^AFULL_THRESH;
  assign awfull_o            = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_port_arbiter.sv
// Bench for fifo_wr_port_arbiter: occupancy/owner model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic with resets.
module tb_fifo_wr_port_arbiter;

  localparam int unsigned A     = 2;
  localparam int unsigned D     = 16;
  localparam int unsigned N     = 4;
  localparam int unsigned TH    = 2;
  localparam int          DEPTH = 4;
  localparam int          PMOD  = 8;

  logic             wclk_i = 1'b0;
  logic             wrst_n_i;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_last_i;
  logic [N*D-1:0]   req_data_i;
  logic [N-1:0]     req_ready_o;
  logic [A:0]       rptr_sync_g_i;
  logic             winc_o;
  logic [A-1:0]     waddr_o;
  logic [D-1:0]     wdata_o;
  logic [A:0]       wptr_g_o;
  logic             wfull_o;
  logic [1:0]       grant_id_o;
  logic             awfull_o;

  fifo_wr_port_arbiter #(
    .ADDRSIZE(A), .DATASIZE(D), .NREQ(N), .AFULL_THRESH(TH)
  ) dut (
    .wclk_i(wclk_i), .wrst_n_i(wrst_n_i),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rptr_sync_g_i(rptr_sync_g_i),
    .winc_o(winc_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .wptr_g_o(wptr_g_o), .wfull_o(wfull_o), .grant_id_o(grant_id_o), .awfull_o(awfull_o)
  );

  always #5 wclk_i = ~wclk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner, lock, total writes and read count (both mod 2*DEPTH)
  int m_owner, m_wcnt, m_rptr;
  bit m_lock, m_full, m_awfull;

  logic [N-1:0] obs_ready;
  logic         obs_full, obs_winc;
  logic [A-1:0] obs_waddr;
  logic [A:0]   obs_wptr;

  logic [N-1:0] rr_exp [4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [N-1:0] lock_exp [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};

  function automatic logic [A:0] gray(input int b);
    logic [A:0] x;
    x = 3'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which requester must be accepted this cycle, -1 if none
  function automatic int pick();
    if (!wrst_n_i || m_full) return -1;
    if (m_lock) return req_valid_i[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid_i[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  task automatic set_rptr(input int r);
    m_rptr        = r % PMOD;
    rptr_sync_g_i = gray(m_rptr);
  endtask

  task automatic model_reset();
    m_owner  = N - 1;
    m_lock   = 1'b0;
    m_wcnt   = 0;
    m_full   = 1'b0;
    m_awfull = 1'b0;
    set_rptr(0);
  endtask

  // One clock: inputs already driven after a negedge; returns at the next negedge
  task automatic cycle();
    int g, occ;
    logic [N-1:0] exp_rdy;
    #1;
    g       = pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", req_ready_o, exp_rdy);
    chk("winc", winc_o, g >= 0);
    chk("waddr", waddr_o, m_wcnt % DEPTH);
    if (g >= 0) chk("wdata", wdata_o, req_data_i[g*D +: D]);
    chk("wptr_g", wptr_g_o, gray(m_wcnt));
    chk("wfull", wfull_o, m_full);
    chk("grant_id", grant_id_o, m_owner);
    chk("awfull", awfull_o, m_awfull);
    obs_ready = req_ready_o;
    obs_full  = wfull_o;
    obs_winc  = winc_o;
    obs_waddr = waddr_o;
    obs_wptr  = wptr_g_o;
    @(posedge wclk_i);
    if (wrst_n_i) begin
      if (g >= 0) begin
        m_owner = g;
        m_lock  = !req_last_i[g];
        m_wcnt  = (m_wcnt + 1) % PMOD;
      end
      occ    = (m_wcnt - m_rptr + PMOD) % PMOD;
      m_full = (occ == DEPTH);
`ifdef FIFO_WR_AFULL_EN
      m_awfull = (occ >= DEPTH - int'(TH));
`endif
    end
    @(negedge wclk_i);
  endtask

  task automatic do_reset(input int n);
    wrst_n_i = 1'b0;
    model_reset();
    repeat (n) cycle();
    wrst_n_i = 1'b1;
  endtask

  initial begin
    wrst_n_i      = 1'b0;
    req_valid_i   = '0;
    req_last_i    = '0;
    req_data_i    = '0;
    rptr_sync_g_i = '0;
    model_reset();
    @(negedge wclk_i);
    req_valid_i = 4'hF;
    req_data_i  = {$urandom, $urandom};
    do_reset(2);
    chk("rst_ready", obs_ready, 4'b0000);
    chk("rst_wptr", obs_wptr, 3'b000);
    chk("rst_grant_id", grant_id_o, 2'd3);

    // Round-robin fill with the reader stopped
    req_last_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_grant", obs_ready, rr_exp[i]);
    end
    cycle();
    chk("rr_full", obs_full, 1'b1);
    chk("rr_stall", obs_ready, 4'b0000);

    // One read frees exactly one slot
    set_rptr(1);
    cycle();
    chk("drain_full_hold", obs_full, 1'b1);
    cycle();
    chk("drain_full_low", obs_full, 1'b0);
    chk("drain_one_write", obs_ready, 4'b0001);
    cycle();
    chk("drain_full_again", obs_full, 1'b1);
    chk("drain_stall", obs_ready, 4'b0000);

    // Burst lock by req1 while req0/req2 also request
    do_reset(1);
    req_valid_i = 4'b0001;
    req_last_i  = 4'b0001;
    cycle();
    req_valid_i = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      req_last_i = (i == 2) ? 4'b0110 : 4'b0100;
      req_data_i = {$urandom, $urandom};
      set_rptr(m_wcnt);
      cycle();
      chk("lock_grant", obs_ready, lock_exp[i]);
    end

    // Reset in the middle of a req3 burst
    do_reset(1);
    req_valid_i = 4'b1000;
    req_last_i  = 4'b0000;
    cycle();
    cycle();
    req_valid_i = 4'hF;
    do_reset(1);
    chk("midrst_ready", obs_ready, 4'b0000);
    chk("midrst_full", obs_full, 1'b0);
    chk("midrst_wptr", obs_wptr, 3'b000);
    req_last_i = 4'hF;
    cycle();
    chk("midrst_first_grant", obs_ready, 4'b0001);

    // Wrap-around with the reader keeping pace
    do_reset(1);
    req_valid_i = 4'b0001;
    req_last_i  = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      set_rptr(m_wcnt);
      cycle();
      chk("wrap_winc", obs_winc, 1'b1);
      chk("wrap_addr", obs_waddr, i % 4);
      if (i == 3) chk("wrap_ptr4", wptr_g_o, 3'b110);
      if (i == 7) chk("wrap_ptr8", wptr_g_o, 3'b000);
    end

    // Randomized traffic, random reader, occasional resets
    do_reset(1);
    for (int c = 0; c < 4000; c++) begin
      req_valid_i = 4'($urandom);
      req_last_i  = 4'($urandom) | 4'($urandom);
      req_data_i  = {$urandom, $urandom};
      if (((m_wcnt - m_rptr + PMOD) % PMOD) > 0 && $urandom_range(1, 0) == 1)
        set_rptr(m_rptr + 1);
      if ($urandom_range(599, 0) == 0) do_reset(1 + $urandom_range(2, 0));
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
